conv2d_result_dma_writer: RTL and testbench

//   Output end of the tiled conv2d pipeline: takes the per-cycle vector of SUM_W-bit MAC results,

---
 rtl/conv2d_result_dma_writer.sv | 144 ++++++++++++++
 tb/tb_conv2d_result_dma_writer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_result_dma_writer.sv
// conv2d_result_dma_writer
//   Output end of the tiled conv2d pipeline. Each beat of PIX_PER_CLK signed MAC
//   sums is requantized (round half up, arithmetic right shift, saturate) to
//   DATA_W bits, buffered in a show-ahead FIFO and streamed to the DMA writer
//   with valid/ready handshaking and a per-tile last marker.
//   The MAC array cannot stall, so a beat arriving at a full FIFO without a
//   simultaneous pop is dropped and the sticky overflow flag is raised.
//   Optional build macro RELU_EN: clamps negative lanes to zero before
//   saturation.
module conv2d_result_dma_writer #(
  parameter int DATA_W       = 8,
  parameter int SUM_W        = 32,
  parameter int PIX_PER_CLK  = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int TILE_BEATS   = 128,
  parameter int AFULL_MARGIN = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic signed [SUM_W-1:0]       in_pixels [PIX_PER_CLK],
  input  logic [4:0]                    shift,
  output logic                          dma_valid,
  input  logic                          dma_ready,
  output logic [DATA_W*PIX_PER_CLK-1:0] dma_pixels,
  output logic                          dma_last,
  output logic                          tile_done,
  output logic                          almost_full,
  output logic                          overflow
);

  localparam int BEAT_W = DATA_W * PIX_PER_CLK;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int BW     = (TILE_BEATS > 1) ? $clog2(TILE_BEATS) : 1;

  localparam logic [CW-1:0] LVL_FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LVL_AFULL = CW'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [BW-1:0] CNT_LAST  = BW'(TILE_BEATS - 1);

  // Saturation bounds expressed in the widened (SUM_W+1) requant domain
  localparam logic signed [SUM_W:0] SAT_MAX = {{(SUM_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W:0] SAT_MIN = {{(SUM_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  // One extra bit keeps x + rounding constant from wrapping for any shift
  function automatic logic signed [SUM_W:0] round_shift(input logic signed [SUM_W-1:0] x,
                                                        input logic [4:0] sh);
    logic signed [SUM_W:0] ext;
    logic signed [SUM_W:0] rnd;
    ext = {x[SUM_W-1], x};
    rnd = {{SUM_W{1'b0}}, 1'b1} << (sh - 5'd1);
    if (sh == 5'd0) return ext;
    return (ext + rnd) >>> sh;
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SUM_W:0] v);
    logic signed [SUM_W:0] c;
    c = v;
`ifdef RELU_EN
    if (c[SUM_W]) c = '0;
`endif
    if (c > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (c < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return c[DATA_W-1:0];
  endfunction

  logic [BEAT_W-1:0] pix_p0;
  logic              vld_p0;

  // ---- stage p0: requantized beat, written into the FIFO on the next edge ----
  // Requantize every lane; data path carries no reset, only the valid does
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int i = 0; i < PIX_PER_CLK; i++) begin
        pix_p0[i*DATA_W +: DATA_W] <= saturate(round_shift(in_pixels[i], shift));
      end
    end
  end

  // Valid companion of the requant stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= in_valid;
  end

  // ---- FIFO: show-ahead, head entry drives the DMA stream ----
  logic [BEAT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     level;
  logic [CW-1:0]     level_nxt;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic [BW-1:0]     beat_cnt;

  assign dma_valid  = (level != '0);
  assign dma_pixels = dma_valid ? mem[rd_ptr] : '0;
  assign dma_last   = dma_valid && (beat_cnt == CNT_LAST);

  // A full FIFO still accepts a beat when the head leaves in the same cycle
  always_comb begin
    pop       = dma_valid && dma_ready;
    push_ok   = vld_p0 && ((level != LVL_FULL) || pop);
    drop      = vld_p0 && (level == LVL_FULL) && !pop;
    level_nxt = level;
    if (push_ok && !pop)      level_nxt = level + 1'b1;
    else if (!push_ok && pop) level_nxt = level - 1'b1;
  end

  // Storage array, written only on accepted beats
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= pix_p0;
  end

  // Pointers, level, threshold and sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      level       <= level_nxt;
      almost_full <= (level_nxt >= LVL_AFULL);
      overflow    <= overflow | drop;
    end
  end

  // Tile beat counter: counts handshakes only, wraps on the last beat of a tile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= pop && dma_last;
      if (pop) beat_cnt <= dma_last ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_conv2d_result_dma_writer.sv
// Bench for conv2d_result_dma_writer (TILE_BEATS overridden to 4).
// Expected beats are queued when stimulus is driven and compared when the DUT
// hands them off; tile markers are predicted from a bench-side beat count.
module tb_conv2d_result_dma_writer;

  localparam int DATA_W = 8;
  localparam int SUM_W  = 32;
  localparam int PPC    = 8;
  localparam int DEPTH  = 16;
  localparam int TILE   = 4;
  localparam int W      = DATA_W * PPC;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic signed [SUM_W-1:0] in_pixels [PPC];
  logic [4:0]              shift = 5'd0;
  logic                    dma_valid;
  logic                    dma_ready = 1'b0;
  logic [W-1:0]            dma_pixels;
  logic                    dma_last;
  logic                    tile_done;
  logic                    almost_full;
  logic                    overflow;

  int checks = 0;
  int failures = 0;
  int hs = 0;
  int lasts = 0;
  int td_seen = 0;
  bit td_exp = 1'b0;
  logic [W-1:0] exp_q [$];

  conv2d_result_dma_writer #(
    .DATA_W(DATA_W), .SUM_W(SUM_W), .PIX_PER_CLK(PPC),
    .FIFO_DEPTH(DEPTH), .TILE_BEATS(TILE), .AFULL_MARGIN(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixels(in_pixels),
    .shift(shift), .dma_valid(dma_valid), .dma_ready(dma_ready),
    .dma_pixels(dma_pixels), .dma_last(dma_last), .tile_done(tile_done),
    .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference requantization: floor division on wide integers
  function automatic logic [DATA_W-1:0] ref_lane(input longint x, input int s);
    longint v, d, num, lim;
    if (s == 0) v = x;
    else begin
      d   = longint'(1) <<< s;
      num = x + d / 2;
      v   = num / d;
      if ((num % d) != 0 && num < 0) v = v - 1;
    end
`ifdef RELU_EN
    if (v < 0) v = 0;
`endif
    lim = longint'(1) <<< (DATA_W - 1);
    if (v > lim - 1) v = lim - 1;
    else if (v < -lim) v = -lim;
    return v[DATA_W-1:0];
  endfunction

  function automatic logic [W-1:0] model_beat();
    logic [W-1:0] r;
    for (int i = 0; i < PPC; i++)
      r[i*DATA_W +: DATA_W] = ref_lane(longint'(in_pixels[i]), int'(shift));
    return r;
  endfunction

  function automatic logic [W-1:0] pack(input int v [PPC]);
    logic [W-1:0] r;
    for (int i = 0; i < PPC; i++) r[i*DATA_W +: DATA_W] = v[i][DATA_W-1:0];
    return r;
  endfunction

  task automatic set_lanes(input int v [PPC]);
    for (int i = 0; i < PPC; i++) in_pixels[i] = v[i];
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < PPC; i++)
      in_pixels[i] = 32'(longint'($urandom_range(0, 131071)) - 65536);
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after a rising edge; drives one input beat
  task automatic push_beat(input logic [W-1:0] exp_pix, input bit accept);
    in_valid = 1'b1;
    if (accept) exp_q.push_back(exp_pix);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || dma_valid) && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    assert (exp_q.size() == 0 && !dma_valid) else begin
      failures++;
      $error("FAIL drain_timeout observed_pending=%0d expected_pending=0", exp_q.size());
    end
  endtask

  // Scoreboard monitor: checks handshaked beats, tile markers and tile_done
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      hs = 0;
      td_exp = 1'b0;
    end else begin
      checks++;
      assert (tile_done === td_exp) else begin
        failures++;
        $error("FAIL tile_done observed=%0b expected=%0b", tile_done, td_exp);
      end
      if (tile_done) td_seen++;
      td_exp = 1'b0;
      if (dma_valid && dma_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_beat observed=%h expected=none", dma_pixels);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          assert (dma_pixels === e) else begin
            failures++;
            $error("FAIL beat%0d observed=%h expected=%h", hs, dma_pixels, e);
          end
        end
        checks++;
        assert (dma_last === ((hs % TILE) == TILE - 1)) else begin
          failures++;
          $error("FAIL dma_last beat%0d observed=%0b expected=%0b", hs, dma_last, (hs % TILE) == TILE - 1);
        end
        if (dma_last) lasts++;
        td_exp = ((hs % TILE) == TILE - 1);
        hs++;
      end
    end
  end

  initial begin
    int a [PPC];
    int b [PPC];
    int hs0, l0, t0;
    for (int i = 0; i < PPC; i++) in_pixels[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", W'(dma_valid), W'(0));
    chk("rst_pixels", dma_pixels, W'(0));
    chk("rst_last", W'(dma_last), W'(0));
    chk("rst_tile_done", W'(tile_done), W'(0));
    chk("rst_afull", W'(almost_full), W'(0));
    chk("rst_overflow", W'(overflow), W'(0));
    step();
    rst_n = 1'b1;
    dma_ready = 1'b1;
    shift = 5'd4;
    step();

    // Requant directed vector and latency
    a = '{100, -100, 7, 8, 40000, -40000, 0, 2047};
`ifdef RELU_EN
    b = '{6, 0, 0, 1, 127, 0, 0, 127};
`else
    b = '{6, -6, 0, 1, 127, -128, 0, 127};
`endif
    set_lanes(a);
    push_beat(pack(b), 1'b1);
    #1 chk("lat_n1", W'(dma_valid), W'(0));
    @(posedge clk);
    #2 chk("lat_n2", W'(dma_valid), W'(1));
    wait_drain(20);

    // shift 0: pure saturation
    shift = 5'd0;
    a = '{127, -128, 128, -129, 0, -1, 5, -5};
`ifdef RELU_EN
    b = '{127, 0, 127, 0, 0, 0, 5, 0};
`else
    b = '{127, -128, 127, -128, 0, -1, 5, -5};
`endif
    set_lanes(a);
    push_beat(pack(b), 1'b1);
    wait_drain(20);

    // Backpressure: fill to 16, overflow on 17th, drain exactly 16
    shift = 5'd8;
    dma_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      rand_lanes();
      push_beat(model_beat(), 1'b1);
    end
    step(); step();
    chk("afull_lvl12", W'(almost_full), W'(0));
    rand_lanes();
    push_beat(model_beat(), 1'b1);
    step(); step();
    chk("afull_lvl13", W'(almost_full), W'(1));
    for (int k = 0; k < 3; k++) begin
      rand_lanes();
      push_beat(model_beat(), 1'b1);
    end
    step(); step();
    chk("ovf_lvl16", W'(overflow), W'(0));
    chk("afull_lvl16", W'(almost_full), W'(1));
    rand_lanes();
    push_beat(model_beat(), 1'b0);
    step(); step();
    chk("ovf_beat17", W'(overflow), W'(1));
    hs0 = hs;
    dma_ready = 1'b1;
    wait_drain(100);
    chk("drain_count", W'(hs - hs0), W'(16));
    chk("ovf_sticky", W'(overflow), W'(1));

    // Reset mid-stream with a partial tile and queued beats
    dma_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_lanes();
      push_beat(model_beat(), 1'b1);
    end
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", W'(dma_valid), W'(0));
    chk("mid_rst_pixels", dma_pixels, W'(0));
    chk("mid_rst_last", W'(dma_last), W'(0));
    chk("mid_rst_tile_done", W'(tile_done), W'(0));
    chk("mid_rst_afull", W'(almost_full), W'(0));
    chk("mid_rst_overflow", W'(overflow), W'(0));
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();

    // Full FIFO with simultaneous pop and push
    for (int k = 0; k < 16; k++) begin
      rand_lanes();
      push_beat(model_beat(), 1'b1);
    end
    step(); step();
    chk("fp_afull", W'(almost_full), W'(1));
    rand_lanes();
    push_beat(model_beat(), 1'b1);
    dma_ready = 1'b1;
    step();
    dma_ready = 1'b0;
    #1 chk("fp_no_overflow", W'(overflow), W'(0));
    step();
    hs0 = hs;
    dma_ready = 1'b1;
    wait_drain(100);
    chk("fp_level16", W'(hs - hs0), W'(16));

    // Tiling under random ready, counter restarted by reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    l0 = lasts;
    t0 = td_seen;
    for (int k = 0; k < 10; k++) begin
      rand_lanes();
      dma_ready = 1'($urandom_range(0, 1));
      push_beat(model_beat(), 1'b1);
    end
    dma_ready = 1'b1;
    wait_drain(100);
    step(); step();
    chk("tile_last_count", W'(lasts - l0), W'(2));
    chk("tile_done_count", W'(td_seen - t0), W'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
